// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Main control FSM and ALU decoder for the multicycle MIPS core. The FSM is
//   Moore-style. The only Mealy term is the branch PC enable, which follows
//   ZeroFlag within the BRANCH cycle.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   Op, Funct       instr[31:26], instr[5:0] from the instruction register
//   ZeroFlag        ALU zero flag from the datapath (combinational)
//   MemtoReg, RegDst, IorD, PCSrc, ALUScrB, ALUSrcA   datapath mux selects
//   IRWrite, MemWrite, RegWrite, PCEn                 load/write enables
//   ALUControl      010 add, 110 sub, 000 and, 001 or, 111 slt
//   IllegalOp       high in DECODE when Op is unsupported
//   State           current state, exported for debug
module multicycle_control_unit #(
  parameter int ALU_Decoder_Size             = 3,
  parameter int ScrB_Mux_Selection_Line_Size = 2,
  parameter int State_Size                   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [5:0]                              Op,
  input  logic [5:0]                              Funct,
  input  logic                                    ZeroFlag,
  output logic                                    MemtoReg,
  output logic                                    RegDst,
  output logic                                    IorD,
  output logic [1:0]                              PCSrc,
  output logic [ScrB_Mux_Selection_Line_Size-1:0] ALUScrB,
  output logic                                    ALUSrcA,
  output logic                                    IRWrite,
  output logic                                    MemWrite,
  output logic                                    RegWrite,
  output logic                                    PCEn,
  output logic [ALU_Decoder_Size-1:0]             ALUControl,
  output logic                                    IllegalOp,
  output logic [State_Size-1:0]                   State
);

  localparam logic [State_Size-1:0] S_FETCH   = State_Size'(0);
  localparam logic [State_Size-1:0] S_DECODE  = State_Size'(1);
  localparam logic [State_Size-1:0] S_MEMADR  = State_Size'(2);
  localparam logic [State_Size-1:0] S_MEMRD   = State_Size'(3);
  localparam logic [State_Size-1:0] S_MEMWB   = State_Size'(4);
  localparam logic [State_Size-1:0] S_MEMWR   = State_Size'(5);
  localparam logic [State_Size-1:0] S_EXECUTE = State_Size'(6);
  localparam logic [State_Size-1:0] S_ALUWB   = State_Size'(7);
  localparam logic [State_Size-1:0] S_BRANCH  = State_Size'(8);
  localparam logic [State_Size-1:0] S_ADDIEXE = State_Size'(9);
  localparam logic [State_Size-1:0] S_ADDIWB  = State_Size'(10);
  localparam logic [State_Size-1:0] S_JUMP    = State_Size'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALU_Decoder_Size-1:0] ALU_ADD = ALU_Decoder_Size'(3'b010);
  localparam logic [ALU_Decoder_Size-1:0] ALU_SUB = ALU_Decoder_Size'(3'b110);
  localparam logic [ALU_Decoder_Size-1:0] ALU_AND = ALU_Decoder_Size'(3'b000);
  localparam logic [ALU_Decoder_Size-1:0] ALU_OR  = ALU_Decoder_Size'(3'b001);
  localparam logic [ALU_Decoder_Size-1:0] ALU_SLT = ALU_Decoder_Size'(3'b111);

  localparam logic [ScrB_Mux_Selection_Line_Size-1:0] SRCB_RD2  = ScrB_Mux_Selection_Line_Size'(2'b00);
  localparam logic [ScrB_Mux_Selection_Line_Size-1:0] SRCB_INC  = ScrB_Mux_Selection_Line_Size'(2'b01);
  localparam logic [ScrB_Mux_Selection_Line_Size-1:0] SRCB_IMM  = ScrB_Mux_Selection_Line_Size'(2'b10);
  localparam logic [ScrB_Mux_Selection_Line_Size-1:0] SRCB_IMM4 = ScrB_Mux_Selection_Line_Size'(2'b11);

  logic [State_Size-1:0] state, state_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next-state logic. Writeback/terminal states and unused encodings
  // all fall through to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXE;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      // IR is stable, so Op is re-sampled here to split loads from stores
      S_MEMADR:  state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = S_MEMWB;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ADDIEXE: state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    IorD       = 1'b0;
    PCSrc      = 2'b00;
    ALUScrB    = SRCB_RD2;
    ALUSrcA    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    PCEn       = 1'b0;
    ALUControl = ALU_ADD;
    IllegalOp  = 1'b0;
    case (state)
      S_FETCH: begin
        ALUScrB = SRCB_INC;
        IRWrite = 1'b1;
        PCEn    = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here
        ALUScrB = SRCB_IMM4;
        case (Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: IllegalOp = 1'b0;
          default:                                       IllegalOp = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUScrB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        // Unsupported funct falls back to add; writeback still happens
        case (Funct)
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        PCEn       = ZeroFlag;  // Mealy: follows the flag in the same cycle
      end
      S_ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUScrB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule
